mdu_seq: RTL
============

Name: mdu_seq

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file read ports.
- Takes rd1/rd2 as operands a/b and computes MULT/MULTU/DIV/DIVU into private HI/LO registers.
- Also executes MTHI/MTLO.
- HI/LO are readable combinationally for MFHI/MFLO; the controller stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- a  input  WIDTH  operand A (rs): multiplicand/dividend; MTHI/MTLO source.
- b  input  WIDTH  operand B (rt): multiplier/divisor.
- busy  output  1  high while an arithmetic op is in flight.
- done  output  1  one-cycle pulse after HI/LO take an arithmetic result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - hi=0, lo=0, busy=0, done=0, state IDLE.
  - Any in-flight op is discarded; HI/LO are not written.
- States: IDLE, RUN, FIN.
- IDLE, start=1 at edge E0:
  - MULT/MULTU/DIV/DIVU: latch operands (magnitudes plus sign flags for signed ops), counter=WIDTH-1, go to RUN.
  - MTHI: hi<=a at E0. MTLO: lo<=a at E0. Stay IDLE, no busy, no done.
  - 11x: ignored.
- RUN: one iteration per edge (E1..E32 for WIDTH=32); counter decrements; go to FIN after the edge where counter=0.
  - Multiply: shift-add on magnitudes into a 2*WIDTH product.
  - Divide: restoring shift-subtract on magnitudes.
- FIN, edge E33:
  - Apply sign correction and write hi/lo.
  - done<=1, go to IDLE.
- Timing:
  - busy is high from the cycle after E0 through the FIN cycle (33 cycles); busy is combinational from state.
  - done is high only between E33 and E34.
  - Next start is accepted at E34 or later.
- start while busy: ignored; op/a/b are don't-care after E0.
- Multiply results:
  - {hi,lo} = full 2*WIDTH product.
  - Signed: negate the product if the operand signs differ.
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Truncation toward zero.
- Divide by zero (b=0, signed or unsigned): hi=a, lo=all ones; sign correction is bypassed.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Magnitude of 0x80000000 is handled as unsigned 0x80000000; internal datapaths are WIDTH+1 bits where needed.
- hi/lo hold their value except on E0 for MTHI/MTLO and on E33 in FIN.

Optional Feature:
- Macro: MDU_EARLY_MUL_EN.
- Defined:
  - Multiply ops check the remaining multiplier bits each RUN cycle.
  - When all remaining multiplier bits are zero, the unit jumps to FIN on the next edge; the partial product is shifted into its final position in one step.
  - Example: b=3 finishes RUN after 2 iterations; done occurs 4 cycles after E0.
  - Divide timing is unchanged.
- Undefined: every multiply takes the full WIDTH RUN cycles, and the timing is as described above.

Test Plan:
- Reset mid-op: assert reset_n=0 during RUN -> busy=0, done=0, hi/lo remain 0; the next start works normally.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after E33, hi=0xFFFFFFFE, lo=0x00000001; done is a single pulse; busy is high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MTHI a=0x12345678 -> hi=0x12345678 on the next edge, with no busy and no done.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- Boundaries:
  - DIVU a=0x1234, b=0 -> hi=0x1234, lo=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start ignored while busy: start=1 with op=MTLO at cycle 10 of a MULTU -> lo is unaffected; the MULTU result is correct; a start at E34 is accepted.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU unit with private HI/LO and MTHI/MTLO.
// Define MDU_EARLY_MUL_EN to let multiplies finish once the remaining multiplier bits are zero.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d, opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
    logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
    logic a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
    logic [WIDTH:0] sum, sh;
    logic [WIDTH+1:0] diff;
    logic [2*WIDTH-1:0] prod;
    // rem_q holds the upper partial product (multiply) or partial remainder (divide);
    // quo_q holds the multiplier being shifted out (multiply) or dividend/quotient (divide).
    always_comb begin
        a_neg = !op[0] && a[WIDTH-1];
        b_neg = !op[0] && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        sum = rem_q + (quo_q[0] ? {1'b0, opb_q} : '0);
        sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff = {1'b0, sh} - {2'b0, opb_q};
        prod = neg_q ? -{rem_q[WIDTH-1:0], quo_q} : {rem_q[WIDTH-1:0], quo_q};
        quo_fix = neg_q ? -quo_q : quo_q;
        rem_fix = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        state_d = state_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        opb_d = opb_q;
        hi_d = hi_q;
        lo_d = lo_q;
        div_d = div_q;
        neg_d = neg_q;
        rneg_d = rneg_q;
        dz_d = dz_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !op[2]) begin
                    state_d = RUN;
                    cnt_d = CMAX;
                    div_d = op[1];
                    neg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    dz_d = op[1] && (b == '0);
                    rem_d = '0;
                    quo_d = op[1] ? a_mag : b_mag;
                    opb_d = op[1] ? b_mag : a_mag;
                end else if (start && !op[1]) begin
                    hi_d = op[0] ? hi_q : a;
                    lo_d = op[0] ? a : lo_q;
                end
            end
            RUN: begin
                rem_d = div_q ? (diff[WIDTH+1] ? sh : diff[WIDTH:0]) : {1'b0, sum[WIDTH:1]};
                quo_d = div_q ? {quo_q[WIDTH-2:0], !diff[WIDTH+1]} : {sum[0], quo_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? FIN : RUN;
`ifdef MDU_EARLY_MUL_EN
                // Remaining multiplier bits are quo_q[cnt_q:0]; if all zero, align the product now.
                if (!div_q && ((quo_q << (CMAX - cnt_q)) == '0)) begin
                    {rem_d, quo_d} = ({rem_q, quo_q} >> cnt_q) >> 1;
                    state_d = FIN;
                end
`endif
            end
            FIN: begin
                state_d = IDLE;
                done_d = 1'b1;
                hi_d = div_q ? rem_fix : prod[2*WIDTH-1:WIDTH];
                lo_d = div_q ? (dz_q ? '1 : quo_fix) : prod[WIDTH-1:0];
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            opb_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            opb_q <= opb_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            div_q <= div_d;
            neg_q <= neg_d;
            rneg_q <= rneg_d;
            dz_q <= dz_d;
            done_q <= done_d;
        end
    end
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi = hi_q;
    assign lo = lo_q;
endmodule
